// File: rtl/ps2_key_decoder_if.sv
// PS/2 keyboard lines plus the decoded key-state outputs of ps2_key_decoder.
// slave is the decoder side; master is the keyboard/consumer side.
interface ps2_key_decoder_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] scan_code;
   logic       scan_valid;
   logic       frame_err;
   logic       ps2_left;
   logic       ps2_right;
   logic [1:0] ps2_mode;

   modport slave (
      input  ps2_clk, ps2_data,
      output scan_code, scan_valid, frame_err, ps2_left, ps2_right, ps2_mode
   );

   modport master (
      output ps2_clk, ps2_data,
      input  scan_code, scan_valid, frame_err, ps2_left, ps2_right, ps2_mode
   );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 receiver: synchronize and filter the keyboard lines, assemble 11-bit frames,
// then track make/break/extended prefixes into held-key and mode outputs.
module ps2_key_decoder #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic               clk,
   input  logic               rst,
   ps2_key_decoder_if.slave   bus
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
   localparam logic [FW-1:0] F_ONE  = FW'(1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] T_ONE  = TW'(1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

   function automatic logic frame_odd(input logic [8:0] v);
      return ^v;
   endfunction

   logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic          filt_q, filt_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          fall;
   state_e        state_q, state_d;
   logic [2:0]    bcnt_q, bcnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [7:0]    code_q, code_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;
   logic          brk_q, brk_d;
   logic          ext_q, ext_d;
   logic          key_a_q, key_a_d;
   logic          key_la_q, key_la_d;
   logic          key_d_q, key_d_d;
   logic          key_ra_q, key_ra_d;
   logic [1:0]    mode_q, mode_d;

   always_comb begin
      filt_d   = filt_q;
      fcnt_d   = fcnt_q;
      fall     = 1'b0;
      state_d  = state_q;
      bcnt_d   = bcnt_q;
      shift_d  = shift_q;
      par_d    = par_q;
      tcnt_d   = tcnt_q;
      code_d   = code_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      brk_d    = brk_q;
      ext_d    = ext_q;
      key_a_d  = key_a_q;
      key_la_d = key_la_q;
      key_d_d  = key_d_q;
      key_ra_d = key_ra_q;
      mode_d   = mode_q;

      // Filtered clock flips on the FILTER_LEN-th consecutive differing sample.
      if (clk_s2_q != filt_q) begin
         if (fcnt_q == F_LAST) begin
            filt_d = clk_s2_q;
            fcnt_d = '0;
            fall   = filt_q;
         end else begin
            fcnt_d = fcnt_q + F_ONE;
         end
      end else begin
         fcnt_d = '0;
      end

      case (state_q)
         S_IDLE: begin
            tcnt_d = '0;
            if (fall && !dat_s2_q) begin
               state_d = S_DATA;
               bcnt_d  = '0;
            end
         end
         S_DATA: begin
            if (fall) begin
               shift_d = {dat_s2_q, shift_q[7:1]};
               bcnt_d  = bcnt_q + 3'd1;
               if (bcnt_q == 3'd7) state_d = S_PARITY;
            end
         end
         S_PARITY: begin
            if (fall) begin
               par_d   = dat_s2_q;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (fall) begin
               state_d = S_IDLE;
               if (dat_s2_q && frame_odd({shift_q, par_q})) begin
                  code_d  = shift_q;
                  valid_d = 1'b1;
                  if (shift_q == 8'hF0) begin
                     brk_d = 1'b1;
                  end else if (shift_q == 8'hE0) begin
                     ext_d = 1'b1;
                  end else begin
                     case ({ext_q, shift_q})
                        9'h01C: key_a_d  = !brk_q;
                        9'h16B: key_la_d = !brk_q;
                        9'h023: key_d_d  = !brk_q;
                        9'h174: key_ra_d = !brk_q;
                        9'h016: if (!brk_q) mode_d = 2'd1;
                        9'h01E: if (!brk_q) mode_d = 2'd2;
                        9'h026: if (!brk_q) mode_d = 2'd3;
                        9'h076: if (!brk_q) mode_d = 2'd0;
                        default: ;
                     endcase
                     brk_d = 1'b0;
                     ext_d = 1'b0;
                  end
               end else begin
                  err_d = 1'b1;
                  brk_d = 1'b0;
                  ext_d = 1'b0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A stalled frame is silently dropped; prefix flags survive.
      if (state_q != S_IDLE) begin
         if (fall) begin
            tcnt_d = '0;
         end else if (tcnt_q == T_LAST) begin
            state_d = S_IDLE;
            tcnt_d  = '0;
         end else begin
            tcnt_d = tcnt_q + T_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
         filt_q   <= 1'b1;
         fcnt_q   <= '0;
         state_q  <= S_IDLE;
         bcnt_q   <= '0;
         tcnt_q   <= '0;
         code_q   <= 8'h00;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         brk_q    <= 1'b0;
         ext_q    <= 1'b0;
         key_a_q  <= 1'b0;
         key_la_q <= 1'b0;
         key_d_q  <= 1'b0;
         key_ra_q <= 1'b0;
         mode_q   <= 2'd0;
      end else begin
         clk_s1_q <= bus.ps2_clk;
         clk_s2_q <= clk_s1_q;
         dat_s1_q <= bus.ps2_data;
         dat_s2_q <= dat_s1_q;
         filt_q   <= filt_d;
         fcnt_q   <= fcnt_d;
         state_q  <= state_d;
         bcnt_q   <= bcnt_d;
         tcnt_q   <= tcnt_d;
         code_q   <= code_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         brk_q    <= brk_d;
         ext_q    <= ext_d;
         key_a_q  <= key_a_d;
         key_la_q <= key_la_d;
         key_d_q  <= key_d_d;
         key_ra_q <= key_ra_d;
         mode_q   <= mode_d;
      end
   end

   // Frame shift register and parity bit are pure datapath.
   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      par_q   <= par_d;
   end

   assign bus.scan_code  = code_q;
   assign bus.scan_valid = valid_q;
   assign bus.frame_err  = err_q;
   assign bus.ps2_left   = key_a_q | key_la_q;
   assign bus.ps2_right  = key_d_q | key_ra_q;
   assign bus.ps2_mode   = mode_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: bit-level PS/2 keyboard driver and a key-set reference model.
module tb_ps2_key_decoder;

   logic clk;
   logic rst;
   ps2_key_decoder_if bus();

   ps2_key_decoder #(.FILTER_LEN(4), .TIMEOUT_CYCLES(200)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cmp_n  = 0;
   int fail_n = 0;

   // Pulse monitor
   int   nv = 0, ne = 0;
   bit   both_seen = 0, wide_seen = 0;
   logic prev_v = 0, prev_e = 0;
   logic cap_left, cap_right;
   logic [1:0] cap_mode;
   logic [7:0] cap_code;
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.scan_valid) begin
            nv++;
            cap_left  = bus.ps2_left;
            cap_right = bus.ps2_right;
            cap_mode  = bus.ps2_mode;
            cap_code  = bus.scan_code;
         end
         if (bus.frame_err) ne++;
         if (bus.scan_valid && bus.frame_err) both_seen = 1;
         if ((bus.scan_valid && prev_v) || (bus.frame_err && prev_e)) wide_seen = 1;
      end
      prev_v = bus.scan_valid;
      prev_e = bus.frame_err;
   end

   // Reference model: set of held keys indexed by {extended, code}
   bit         held [0:511];
   bit         brk_m, ext_m;
   logic [1:0] mode_m;
   logic [7:0] code_m;

   function automatic void model_reset();
      foreach (held[i]) held[i] = 0;
      brk_m = 0; ext_m = 0; mode_m = 0; code_m = 8'h00;
   endfunction

   function automatic void model_apply(input logic [7:0] b, input bit good);
      int key;
      if (!good) begin
         brk_m = 0; ext_m = 0;
         return;
      end
      code_m = b;
      if (b == 8'hF0) brk_m = 1;
      else if (b == 8'hE0) ext_m = 1;
      else begin
         key = ext_m ? 256 + int'(b) : int'(b);
         if (key == 'h01C || key == 'h16B || key == 'h023 || key == 'h174) held[key] = !brk_m;
         if (!brk_m && !ext_m) begin
            if (b == 8'h16) mode_m = 1;
            if (b == 8'h1E) mode_m = 2;
            if (b == 8'h26) mode_m = 3;
            if (b == 8'h76) mode_m = 0;
         end
         brk_m = 0; ext_m = 0;
      end
   endfunction

   function automatic logic exp_left();
      return held['h01C] | held['h16B];
   endfunction
   function automatic logic exp_right();
      return held['h023] | held['h174];
   endfunction

   // Keyboard driver: data changes mid-high, clock low for 20 cycles
   task automatic drive_bit(input logic b);
      @(posedge clk); #1 bus.ps2_data = b;
      repeat (10) @(posedge clk);
      #1 bus.ps2_clk = 1'b0;
      repeat (20) @(posedge clk);
      #1 bus.ps2_clk = 1'b1;
      repeat (9) @(posedge clk);
   endtask

   int dv, de;
   task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      int v0, e0;
      logic p;
      v0 = nv; e0 = ne;
      p = ~^b;
      if (bad_par) p = ~p;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(p);
      drive_bit(bad_stop ? 1'b0 : 1'b1);
      bus.ps2_data = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      dv = nv - v0;
      de = ne - e0;
      model_apply(b, !bad_par && !bad_stop);
   endtask

   task automatic test_reset();
      bus.ps2_clk = 1'b1; bus.ps2_data = 1'b1; rst = 1'b1;
      model_reset();
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      cmp_n++; if (bus.scan_code !== 8'h00) begin fail_n++; $display("FAIL reset_code: got %h want 00", bus.scan_code); end
      cmp_n++; if ({bus.scan_valid, bus.frame_err, bus.ps2_left, bus.ps2_right, bus.ps2_mode} !== 6'b0) begin
         fail_n++; $display("FAIL reset_outs: got %b want 000000", {bus.scan_valid, bus.frame_err, bus.ps2_left, bus.ps2_right, bus.ps2_mode}); end
   endtask

   task automatic test_left();
      logic [7:0] seq [3] = '{8'h1C, 8'hF0, 8'h1C};
      for (int i = 0; i < 3; i++) begin
         send_byte(seq[i], 0, 0);
         cmp_n++; if (dv !== 1) begin fail_n++; $display("FAIL left_valid[%0d]: got %0d pulses want 1", i, dv); end
         cmp_n++; if (bus.scan_code !== seq[i]) begin fail_n++; $display("FAIL left_code[%0d]: got %h want %h", i, bus.scan_code, seq[i]); end
         cmp_n++; if (cap_left !== exp_left()) begin fail_n++; $display("FAIL left_at_pulse[%0d]: got %b want %b", i, cap_left, exp_left()); end
      end
      cmp_n++; if (bus.ps2_left !== 1'b0) begin fail_n++; $display("FAIL left_released: got %b want 0", bus.ps2_left); end
   endtask

   task automatic test_right();
      logic [7:0] seq [8] = '{8'hE0, 8'h74, 8'h23, 8'hE0, 8'hF0, 8'h74, 8'hF0, 8'h23};
      logic       want [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
      for (int i = 0; i < 8; i++) begin
         send_byte(seq[i], 0, 0);
         cmp_n++; if (bus.ps2_right !== exp_right()) begin fail_n++; $display("FAIL right_model[%0d]: got %b want %b", i, bus.ps2_right, exp_right()); end
         cmp_n++; if (bus.ps2_right !== want[i]) begin fail_n++; $display("FAIL right_plan[%0d]: got %b want %b", i, bus.ps2_right, want[i]); end
      end
   endtask

   task automatic test_mode();
      logic [7:0] seq [5]  = '{8'h1E, 8'hF0, 8'h1E, 8'h26, 8'h76};
      logic [1:0] want [5] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
      for (int i = 0; i < 5; i++) begin
         send_byte(seq[i], 0, 0);
         cmp_n++; if (bus.ps2_mode !== want[i] || bus.ps2_mode !== mode_m) begin
            fail_n++; $display("FAIL mode[%0d]: got %0d want %0d", i, bus.ps2_mode, want[i]); end
      end
   endtask

   task automatic test_errors();
      logic [7:0] code0;
      code0 = bus.scan_code;
      send_byte(8'h1C, 1, 0);
      cmp_n++; if (de !== 1 || dv !== 0) begin fail_n++; $display("FAIL err_parity: got err=%0d valid=%0d want 1/0", de, dv); end
      cmp_n++; if (bus.ps2_left !== 1'b0) begin fail_n++; $display("FAIL err_parity_left: got %b want 0", bus.ps2_left); end
      cmp_n++; if (bus.scan_code !== code0) begin fail_n++; $display("FAIL err_parity_code: got %h want %h", bus.scan_code, code0); end
      send_byte(8'hF0, 0, 1);
      cmp_n++; if (de !== 1 || dv !== 0) begin fail_n++; $display("FAIL err_stop: got err=%0d valid=%0d want 1/0", de, dv); end
      send_byte(8'h1C, 0, 0);
      cmp_n++; if (bus.ps2_left !== 1'b1) begin fail_n++; $display("FAIL err_then_make: got %b want 1", bus.ps2_left); end
      send_byte(8'hF0, 0, 0);
      send_byte(8'h1C, 0, 0);
      cmp_n++; if (bus.ps2_left !== exp_left()) begin fail_n++; $display("FAIL err_release: got %b want %b", bus.ps2_left, exp_left()); end
   endtask

   task automatic test_timeout_glitch();
      int v0, e0;
      v0 = nv; e0 = ne;
      for (int i = 0; i < 4; i++) drive_bit(1'b0);
      repeat (250) @(posedge clk);
      #1;
      cmp_n++; if (ne !== e0 || nv !== v0) begin fail_n++; $display("FAIL timeout_silent: got err=%0d valid=%0d want 0/0", ne - e0, nv - v0); end
      send_byte(8'h23, 0, 0);
      cmp_n++; if (de !== 0 || bus.scan_code !== 8'h23) begin fail_n++; $display("FAIL timeout_next: got err=%0d code=%h want 0/23", de, bus.scan_code); end
      cmp_n++; if (bus.ps2_right !== 1'b1) begin fail_n++; $display("FAIL timeout_right: got %b want 1", bus.ps2_right); end
      bus.ps2_data = 1'b0;
      v0 = nv; e0 = ne;
      for (int g = 0; g < 5; g++) begin
         @(posedge clk); #1 bus.ps2_clk = 1'b0;
         repeat (2) @(posedge clk);
         #1 bus.ps2_clk = 1'b1;
         repeat (10) @(posedge clk);
      end
      bus.ps2_data = 1'b1;
      repeat (250) @(posedge clk);
      #1;
      cmp_n++; if (ne !== e0 || nv !== v0) begin fail_n++; $display("FAIL glitch_pulses: got err=%0d valid=%0d want 0/0", ne - e0, nv - v0); end
      send_byte(8'hF0, 0, 0);
      send_byte(8'h23, 0, 0);
      cmp_n++; if (de !== 0 || bus.ps2_right !== 1'b0) begin fail_n++; $display("FAIL glitch_release: got err=%0d right=%b want 0/0", de, bus.ps2_right); end
   endtask

   task automatic test_reset_mid_frame();
      send_byte(8'h1C, 0, 0);
      send_byte(8'h16, 0, 0);
      cmp_n++; if (bus.ps2_left !== 1'b1) begin fail_n++; $display("FAIL rstmid_pre: got %b want 1", bus.ps2_left); end
      drive_bit(1'b0);
      drive_bit(1'b1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      model_reset();
      @(negedge clk);
      cmp_n++; if ({bus.scan_code, bus.scan_valid, bus.frame_err, bus.ps2_left, bus.ps2_right, bus.ps2_mode} !== 14'b0) begin
         fail_n++; $display("FAIL rstmid_outs: got code=%h left=%b right=%b mode=%0d want all 0", bus.scan_code, bus.ps2_left, bus.ps2_right, bus.ps2_mode); end
      repeat (20) @(posedge clk);
      send_byte(8'h1C, 0, 0);
      cmp_n++; if (bus.ps2_left !== 1'b1 || bus.scan_code !== 8'h1C) begin
         fail_n++; $display("FAIL rstmid_after: got left=%b code=%h want 1/1c", bus.ps2_left, bus.scan_code); end
   endtask

   task automatic test_random();
      logic [7:0] pool [10] = '{8'h1C, 8'h23, 8'h6B, 8'h74, 8'h16, 8'h1E, 8'h26, 8'h76, 8'hF0, 8'hE0};
      logic [7:0] b;
      bit bp, bs;
      for (int n = 0; n < 40; n++) begin
         b  = ($urandom_range(0, 9) < 7) ? pool[$urandom_range(0, 9)] : 8'($urandom());
         bp = ($urandom_range(0, 11) == 0);
         bs = !bp && ($urandom_range(0, 15) == 0);
         send_byte(b, bp, bs);
         cmp_n++; if (dv !== ((bp || bs) ? 0 : 1) || de !== ((bp || bs) ? 1 : 0)) begin
            fail_n++; $display("FAIL rnd_pulse[%0d]: got valid=%0d err=%0d for %h bad=%b%b", n, dv, de, b, bp, bs); end
         cmp_n++; if (bus.scan_code !== code_m) begin fail_n++; $display("FAIL rnd_code[%0d]: got %h want %h", n, bus.scan_code, code_m); end
         cmp_n++; if (bus.ps2_left !== exp_left() || bus.ps2_right !== exp_right()) begin
            fail_n++; $display("FAIL rnd_keys[%0d]: got l=%b r=%b want l=%b r=%b", n, bus.ps2_left, bus.ps2_right, exp_left(), exp_right()); end
         cmp_n++; if (bus.ps2_mode !== mode_m) begin fail_n++; $display("FAIL rnd_mode[%0d]: got %0d want %0d", n, bus.ps2_mode, mode_m); end
      end
      cmp_n++; if (both_seen !== 1'b0) begin fail_n++; $display("FAIL pulse_overlap: got %b want 0", both_seen); end
      cmp_n++; if (wide_seen !== 1'b0) begin fail_n++; $display("FAIL pulse_width: got %b want 0", wide_seen); end
   endtask

   initial begin
      test_reset();
      test_left();
      test_right();
      test_mode();
      test_errors();
      test_timeout_glitch();
      test_reset_mid_frame();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
